// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the demux_stream block: channel count,
// address width, per-channel FIFO depth, the FIFO occupancy type, and a helper
// that locates a channel's slice inside a packed per-channel bus.
// No ports (package).
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_CH     = 4;
    localparam int ADDR_W     = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_EMPTY = '0;
    localparam cnt_t CNT_FULL  = cnt_t'(FIFO_DEPTH);

    // Channel 0 occupies the most significant slice of a packed bus.
    function automatic int slice_lsb(input int width, input int ch);
        return width * (NUM_CH - 1 - ch);
    endfunction

endpackage

// File: rtl/demux_stream_if.sv
// -----------------------------------------------------------------------------
// demux_stream_if
// Stream bus between a producer/consumer (master) and demux_stream (slave).
// Signals:
//   data_in   [WIDTH]        word to be routed
//   address   [2]            destination channel 0..3
//   in_valid                 data_in/address valid
//   in_ready                 block accepts the word this cycle
//   data_out  [4*WIDTH]      packed channel heads, channel 0 in the MSBs
//   out_valid [4]            per-channel head valid
//   out_ready [4]            per-channel consumer takes head
// -----------------------------------------------------------------------------
interface demux_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0]        data_in;
    logic [ADDR_W-1:0]       address;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] data_out;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;

    modport master (
        output data_in, address, in_valid, out_ready,
        input  in_ready, data_out, out_valid
    );

    modport slave (
        input  data_in, address, in_valid, out_ready,
        output in_ready, data_out, out_valid
    );

endinterface

// File: rtl/demux_chan_fifo.sv
// -----------------------------------------------------------------------------
// demux_chan_fifo
// Two-entry FIFO for one demux channel. Push and pop may happen on the same
// edge; a push into a full FIFO or a pop from an empty one is ignored.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (clears storage and pointers)
//   push_i   in   write din_i this edge
//   pop_i    in   drop the head this edge
//   din_i    in   [WIDTH] word to write
//   head_o   out  [WIDTH] oldest entry (registered state only)
//   count_o  out  occupancy 0..2
// -----------------------------------------------------------------------------
module demux_chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output cnt_t             count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    cnt_t             count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push_i && (count_q != CNT_FULL);
        do_pop   = pop_i && (count_q != CNT_EMPTY);

        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Push and pop together leave the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= CNT_EMPTY;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
// Routes each accepted word to one of four independent 2-entry channel FIFOs
// selected by address. Each channel presents its oldest word on its slice of
// data_out with out_valid[k]; the consumer pops it with out_ready[k].
// A full destination refuses the word even if it delivers in the same cycle.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   bus          slave modport of demux_stream_if (data_in, address,
//                in_valid, in_ready, data_out, out_valid, out_ready)
//   deliv_count  out  [32] four 8-bit wrapping delivery counters, channel 0
//                in the MSBs -- present only with DEMUX_STREAM_COUNT_EN
// Build option: define DEMUX_STREAM_COUNT_EN to add deliv_count.
// -----------------------------------------------------------------------------
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_stream_if.slave        bus
`ifdef DEMUX_STREAM_COUNT_EN
    ,
    output logic [31:0]          deliv_count
`endif
);

    cnt_t                    count_w [NUM_CH];
    logic [NUM_CH-1:0]       push_w;
    logic [NUM_CH-1:0]       pop_w;
    logic [NUM_CH-1:0]       out_valid_w;
    logic [NUM_CH*WIDTH-1:0] data_out_w;
    logic                    accept_w;

    // Readiness depends only on the addressed channel's stored occupancy.
    assign bus.in_ready = (count_w[bus.address] != CNT_FULL);
    assign accept_w     = bus.in_valid && bus.in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        localparam int LSB = slice_lsb(WIDTH, k);

        assign push_w[k]      = accept_w && (bus.address == ADDR_W'(k));
        assign out_valid_w[k] = (count_w[k] != CNT_EMPTY);
        assign pop_w[k]       = out_valid_w[k] && bus.out_ready[k];

        demux_chan_fifo #(
            .WIDTH (WIDTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_w[k]),
            .pop_i   (pop_w[k]),
            .din_i   (bus.data_in),
            .head_o  (data_out_w[LSB +: WIDTH]),
            .count_o (count_w[k])
        );
    end

    assign bus.out_valid = out_valid_w;
    assign bus.data_out  = data_out_w;

`ifdef DEMUX_STREAM_COUNT_EN
    logic [7:0] dcnt_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                dcnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (pop_w[k]) begin
                    dcnt_q[k] <= dcnt_q[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        deliv_count = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            deliv_count[slice_lsb(8, k) +: 8] = dcnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_stream
// Self-checking bench for demux_stream: per-channel queue model, directed
// scenarios with literal expectations, then randomized traffic.
// Build option: DEMUX_STREAM_COUNT_EN also checks deliv_count.
// -----------------------------------------------------------------------------
module tb_demux_stream;
    import demux_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_stream_if #(.WIDTH(W)) bus ();

`ifdef DEMUX_STREAM_COUNT_EN
    logic [31:0] deliv_count;
`endif

    demux_stream #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DEMUX_STREAM_COUNT_EN
        ,
        .deliv_count (deliv_count)
`endif
    );

    int nchk = 0;
    int nerr = 0;

    logic [W-1:0] mq [4][$];
    logic [7:0]   mcnt [4];
    bit           mzero;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] head(input int k);
        return bus.data_out[(3 - k) * W +: W];
    endfunction

    task automatic drive(input logic r, input logic [W-1:0] d, input logic [1:0] a,
                         input logic iv, input logic [3:0] orv);
        rst           = r;
        bus.data_in   = d;
        bus.address   = a;
        bus.in_valid  = iv;
        bus.out_ready = orv;
        #1;
    endtask

    // Compare DUT against the queue model, then advance the model by the
    // transfers the upcoming edge will perform.
    task automatic step();
        bit acc;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(mq[k].size() != 0));
            if (mq[k].size() != 0)
                chk($sformatf("head[%0d]", k), 32'(head(k)), 32'(mq[k][0]));
        end
        if (mzero) chk("data_out_zero", bus.data_out, 32'd0);
        chk("in_ready", 32'(bus.in_ready), 32'(mq[bus.address].size() != 2));
`ifdef DEMUX_STREAM_COUNT_EN
        chk("deliv_count", deliv_count, {mcnt[0], mcnt[1], mcnt[2], mcnt[3]});
`endif
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                mcnt[k] = 8'd0;
            end
            mzero = 1'b1;
        end else begin
            acc = bus.in_valid && (mq[bus.address].size() < 2);
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0 && bus.out_ready[k]) begin
                    void'(mq[k].pop_front());
                    mcnt[k] = mcnt[k] + 8'd1;
                end
            end
            if (acc) begin
                mq[bus.address].push_back(bus.data_in);
                mzero = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, 2'd0, 1'b0, 4'b0000);
        step();
        step();
    endtask

    initial begin
        // Power-up reset before the model is trusted.
        drive(1'b1, '0, 2'd0, 1'b0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mcnt[k] = 8'd0;
        end
        mzero = 1'b1;

        // Reset state.
        drive(1'b0, '0, 2'd0, 1'b0, 4'b0000);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data_out", bus.data_out, 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Single word to channel 2.
        drive(1'b0, 8'd5, 2'd2, 1'b1, 4'b0000);
        step();
        drive(1'b0, 8'd0, 2'd0, 1'b0, 4'b0000);
        chk("c2_out_valid", 32'(bus.out_valid), 32'h4);
        chk("c2_head", 32'(bus.data_out[15:8]), 32'd5);
        step();

        // Channel 0 fills at two words; the third is refused; order kept.
        do_reset();
        drive(1'b0, 8'd1, 2'd0, 1'b1, 4'b0000); step();
        drive(1'b0, 8'd2, 2'd0, 1'b1, 4'b0000); step();
        drive(1'b0, 8'd3, 2'd0, 1'b1, 4'b0000);
        chk("c0_full_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        drive(1'b0, 8'd0, 2'd0, 1'b0, 4'b0001);
        chk("c0_first", 32'(head(0)), 32'd1);
        step();
        chk("c0_second", 32'(head(0)), 32'd2);
        step();
        drive(1'b0, 8'd0, 2'd0, 1'b0, 4'b0000);
        chk("c0_drained", 32'(bus.out_valid[0]), 32'h0);
        step();

        // Stalled full channel 1 does not block channel 3.
        do_reset();
        drive(1'b0, 8'd7, 2'd1, 1'b1, 4'b0000); step();
        drive(1'b0, 8'd8, 2'd1, 1'b1, 4'b0000); step();
        drive(1'b0, 8'd9, 2'd3, 1'b1, 4'b0000);
        chk("c3_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        drive(1'b0, 8'd4, 2'd1, 1'b1, 4'b0000);
        chk("c3_out_valid", 32'(bus.out_valid), 32'ha);
        chk("c3_head", 32'(head(3)), 32'd9);
        chk("c1_head_kept", 32'(head(1)), 32'd7);
        step();

        // Full channel 0 delivering still refuses the incoming word.
        do_reset();
        drive(1'b0, 8'h11, 2'd0, 1'b1, 4'b0000); step();
        drive(1'b0, 8'h22, 2'd0, 1'b1, 4'b0000); step();
        drive(1'b0, 8'h33, 2'd0, 1'b1, 4'b0001);
        chk("c0_full_deliv_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 4'b0001);
        chk("c0_after_refuse", 32'(head(0)), 32'h22);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
        chk("c0_count_was_1", 32'(bus.out_valid[0]), 32'h0);
        step();

        // Reset while every channel holds data, with transfers in flight.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'(8'h40 + k), 2'(k), 1'b1, 4'b0000);
            step();
        end
        drive(1'b1, 8'h55, 2'd1, 1'b1, 4'b1111);
        step();
        drive(1'b0, 8'h00, 2'd1, 1'b0, 4'b0000);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst2_data_out", bus.data_out, 32'h0);
        chk("rst2_in_ready", 32'(bus.in_ready), 32'h1);
        step();

`ifdef DEMUX_STREAM_COUNT_EN
        // 256 deliveries on channel 2 wrap its counter to 0.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            drive(1'b0, 8'(i), 2'd2, 1'b1, 4'b0100);
            step();
        end
        drive(1'b0, 8'd0, 2'd0, 1'b0, 4'b0000);
        chk("c2_count_wrap", 32'(deliv_count[15:8]), 32'h0);
        step();
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  W'($urandom),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)));
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
